// File: rtl/vc_scheduler_if.sv
// Bundles the VC FIFO side, the destination FIFO side and the scheduling
// controls of the transmit-layer VC scheduler into one connection.
interface vc_scheduler_if #(
  parameter int DATA_WIDTH   = 6,
  parameter int WEIGHT_WIDTH = 3
);
  logic                    enable;
  logic [WEIGHT_WIDTH-1:0] weight_VC0;
  logic [WEIGHT_WIDTH-1:0] weight_VC1;
  logic                    empty_fifo_VC0;
  logic                    empty_fifo_VC1;
  logic [DATA_WIDTH-1:0]   data_out_VC0;
  logic [DATA_WIDTH-1:0]   data_out_VC1;
  logic                    almost_full_fifo_D0;
  logic                    almost_full_fifo_D1;
  logic                    pop_VC0_fifo;
  logic                    pop_VC1_fifo;
  logic                    push_D0;
  logic                    push_D1;
  logic [DATA_WIDTH-1:0]   data_D0;
  logic [DATA_WIDTH-1:0]   data_D1;
  logic                    serving_VC1;
  logic                    stall;

  // Scheduler side
  modport master (
    input  enable, weight_VC0, weight_VC1,
    input  empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
    input  almost_full_fifo_D0, almost_full_fifo_D1,
    output pop_VC0_fifo, pop_VC1_fifo,
    output push_D0, push_D1, data_D0, data_D1,
    output serving_VC1, stall
  );

  // FIFO / control side
  modport slave (
    output enable, weight_VC0, weight_VC1,
    output empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
    output almost_full_fifo_D0, almost_full_fifo_D1,
    input  pop_VC0_fifo, pop_VC1_fifo,
    input  push_D0, push_D1, data_D0, data_D1,
    input  serving_VC1, stall
  );
endinterface

// File: rtl/vc_scheduler.sv
// Weighted round-robin scheduler moving words from two VC FIFOs into two
// destination FIFOs. The turn owner keeps popping for weff consecutive pops;
// when it cannot pop, the other VC is served instead so no cycle is wasted.
module vc_scheduler #(
  parameter int DATA_WIDTH   = 6,
  parameter int WEIGHT_WIDTH = 3
) (
  input  logic           clk,
  input  logic           reset,
  vc_scheduler_if.master bus
);

  localparam int DEST_BIT = 4;

  typedef enum logic {SERVE0 = 1'b0, SERVE1 = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [WEIGHT_WIDTH-1:0] cnt_q, cnt_d;

  logic                    pushD0_q, pushD1_q;
  logic [DATA_WIDTH-1:0]   dataD0_q, dataD1_q;
  logic                    stall_q;

  logic                    afVc0, afVc1;
  logic                    elig0, elig1;
  logic [WEIGHT_WIDTH-1:0] weff0, weff1;
  logic                    eligCur, eligOth;
  logic [WEIGHT_WIDTH-1:0] weffCur, weffOth;
  logic [WEIGHT_WIDTH:0]   cntInc;
  state_t                  othState;
  logic                    popCur, popOth;
  logic                    popVc0, popVc1, anyPop;
  logic [DATA_WIDTH-1:0]   popWord;

  // A VC may pop only if its head word's destination FIFO can take one more word
  assign afVc0 = bus.data_out_VC0[DEST_BIT] ? bus.almost_full_fifo_D1 : bus.almost_full_fifo_D0;
  assign afVc1 = bus.data_out_VC1[DEST_BIT] ? bus.almost_full_fifo_D1 : bus.almost_full_fifo_D0;
  assign elig0 = bus.enable & ~reset & ~bus.empty_fifo_VC0 & ~afVc0;
  assign elig1 = bus.enable & ~reset & ~bus.empty_fifo_VC1 & ~afVc1;

  // A zero weight still grants one pop per turn
  assign weff0 = (bus.weight_VC0 == '0) ? WEIGHT_WIDTH'(1) : bus.weight_VC0;
  assign weff1 = (bus.weight_VC1 == '0) ? WEIGHT_WIDTH'(1) : bus.weight_VC1;

  // Map VC0/VC1 onto current-owner / other views of the turn
  always_comb begin
    eligCur  = elig0;
    eligOth  = elig1;
    weffCur  = weff0;
    weffOth  = weff1;
    othState = SERVE1;
    if (state_q == SERVE1) begin
      eligCur  = elig1;
      eligOth  = elig0;
      weffCur  = weff1;
      weffOth  = weff0;
      othState = SERVE0;
    end
  end

  // Turn and credit bookkeeping; the owner pops first, otherwise the other VC fills the slot
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    popCur  = 1'b0;
    popOth  = 1'b0;
    cntInc  = {1'b0, cnt_q} + {{WEIGHT_WIDTH{1'b0}}, 1'b1};
    if (eligCur) begin
      popCur = 1'b1;
      if (cntInc >= {1'b0, weffCur}) begin
        state_d = othState;
        cnt_d   = '0;
      end else begin
        cnt_d = cntInc[WEIGHT_WIDTH-1:0];
      end
    end else if (eligOth) begin
      popOth = 1'b1;
      if (weffOth == WEIGHT_WIDTH'(1)) begin
        state_d = state_q;
        cnt_d   = '0;
      end else begin
        state_d = othState;
        cnt_d   = WEIGHT_WIDTH'(1);
      end
    end
  end

  assign popVc0  = (state_q == SERVE1) ? popOth : popCur;
  assign popVc1  = (state_q == SERVE1) ? popCur : popOth;
  assign anyPop  = popCur | popOth;
  assign popWord = popVc1 ? bus.data_out_VC1 : bus.data_out_VC0;

  // Turn owner and credit counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SERVE0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Register the popped word toward its destination and flag blocked cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pushD0_q <= 1'b0;
      pushD1_q <= 1'b0;
      dataD0_q <= '0;
      dataD1_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      pushD0_q <= anyPop & ~popWord[DEST_BIT];
      pushD1_q <= anyPop & popWord[DEST_BIT];
      if (anyPop && !popWord[DEST_BIT]) begin
        dataD0_q <= popWord;
      end
      if (anyPop && popWord[DEST_BIT]) begin
        dataD1_q <= popWord;
      end
      stall_q <= bus.enable & (~bus.empty_fifo_VC0 | ~bus.empty_fifo_VC1) & ~anyPop;
    end
  end

  assign bus.pop_VC0_fifo = popVc0;
  assign bus.pop_VC1_fifo = popVc1;
  assign bus.push_D0      = pushD0_q;
  assign bus.push_D1      = pushD1_q;
  assign bus.data_D0      = dataD0_q;
  assign bus.data_D1      = dataD1_q;
  assign bus.serving_VC1  = (state_q == SERVE1);
  assign bus.stall        = stall_q;

endmodule

// File: tb/tb_vc_scheduler.sv
// Bench for vc_scheduler: models both VC FIFOs as queues, queues the
// hand-computed push order per scenario and checks it from a negedge monitor.
module tb_vc_scheduler;

  localparam int DW = 6;
  localparam int WW = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  vc_scheduler_if #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) bus ();

  vc_scheduler #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] vc0Q[$];
  logic [DW-1:0] vc1Q[$];
  logic [DW-1:0] expQ[$];
  int errors = 0;
  int checks = 0;

  logic [DW-1:0] monExp;
  logic [DW-1:0] monData;
  logic          monDest;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic refreshInputs();
    bus.empty_fifo_VC0 = (vc0Q.size() == 0);
    bus.empty_fifo_VC1 = (vc1Q.size() == 0);
    bus.data_out_VC0   = (vc0Q.size() != 0) ? vc0Q[0] : '0;
    bus.data_out_VC1   = (vc1Q.size() != 0) ? vc1Q[0] : '0;
  endtask

  // One clock: sample the pop strobes mid-cycle, retire the popped heads after the edge
  task automatic applyStimulus();
    logic p0, p1;
    @(negedge clk);
    p0 = bus.pop_VC0_fifo;
    p1 = bus.pop_VC1_fifo;
    if (p0 && p1) begin
      checkOutput("single pop", {p0, p1}, 2'b01);
    end
    @(posedge clk);
    #1;
    if (p0 && vc0Q.size() != 0) void'(vc0Q.pop_front());
    if (p1 && vc1Q.size() != 0) void'(vc1Q.pop_front());
    refreshInputs();
  endtask

  task automatic drain(input int maxCycles, output int used);
    used = 0;
    while ((vc0Q.size() != 0 || vc1Q.size() != 0) && used < maxCycles) begin
      applyStimulus();
      used++;
    end
    if (vc0Q.size() != 0 || vc1Q.size() != 0) begin
      checkOutput("drain timeout", vc0Q.size() + vc1Q.size(), 0);
    end
    applyStimulus();
    applyStimulus();
    checkOutput("scoreboard empty", expQ.size(), 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    vc0Q.delete();
    vc1Q.delete();
    bus.almost_full_fifo_D0 = 1'b0;
    bus.almost_full_fifo_D1 = 1'b0;
    refreshInputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard: every push must match the next expected word and its destination
  always @(negedge clk) begin
    if (!reset && (bus.push_D0 || bus.push_D1)) begin
      checks++;
      if (bus.push_D0 && bus.push_D1) begin
        errors++;
        $display("[TB] FAIL push exclusive: got D0=1 D1=1 required one");
      end else if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected push: got D1=%0b data %0h required none", bus.push_D1, bus.push_D1 ? bus.data_D1 : bus.data_D0);
      end else begin
        monExp  = expQ.pop_front();
        monDest = bus.push_D1;
        monData = monDest ? bus.data_D1 : bus.data_D0;
        if (monDest !== monExp[4] || monData !== monExp) begin
          errors++;
          $display("[TB] FAIL push word: got D%0d %0h required D%0d %0h", monDest, monData, monExp[4], monExp);
        end
      end
    end
  end

  initial begin
    int used;
    bus.enable              = 1'b1;
    bus.weight_VC0          = 3'd1;
    bus.weight_VC1          = 3'd1;
    bus.almost_full_fifo_D0 = 1'b0;
    bus.almost_full_fifo_D1 = 1'b0;
    vc0Q.push_back(6'h01);
    refreshInputs();

    // Reset state with work waiting
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset pop0", bus.pop_VC0_fifo, 0);
    checkOutput("reset push", {bus.push_D0, bus.push_D1}, 0);
    checkOutput("reset data", {bus.data_D0, bus.data_D1}, 0);
    checkOutput("reset serving", bus.serving_VC1, 0);
    checkOutput("reset stall", bus.stall, 0);

    // Weights 2/1, six words each
    doReset();
    bus.weight_VC0 = 3'd2;
    bus.weight_VC1 = 3'd1;
    vc0Q = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06};
    vc1Q = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D};
    expQ = '{6'h01, 6'h02, 6'h08, 6'h03, 6'h04, 6'h09, 6'h05, 6'h06, 6'h0A, 6'h0B, 6'h0C, 6'h0D};
    refreshInputs();
    drain(40, used);
    checkOutput("wrr burst cycles", used, 12);
    checkOutput("idle stall", bus.stall, 0);

    // VC0 empty, VC1 three words, weights 3/3
    doReset();
    bus.weight_VC0 = 3'd3;
    bus.weight_VC1 = 3'd3;
    vc1Q = '{6'h01, 6'h02, 6'h03};
    expQ = '{6'h01, 6'h02, 6'h03};
    refreshInputs();
    applyStimulus();
    checkOutput("vc1 only serving", bus.serving_VC1, 1);
    checkOutput("vc1 only stall", bus.stall, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("vc1 only stall end", bus.stall, 0);
    checkOutput("vc1 only turn end", bus.serving_VC1, 0);
    drain(4, used);

    // VC0 head to full D1, VC1 head to D0
    doReset();
    bus.weight_VC0 = 3'd1;
    bus.weight_VC1 = 3'd1;
    bus.almost_full_fifo_D1 = 1'b1;
    vc0Q = '{6'h10};
    vc1Q = '{6'h00};
    expQ = '{6'h00, 6'h10};
    refreshInputs();
    applyStimulus();
    checkOutput("af bypass stall", bus.stall, 0);
    applyStimulus();
    checkOutput("af blocked stall", bus.stall, 1);
    bus.almost_full_fifo_D1 = 1'b0;
    drain(4, used);
    checkOutput("af release cycles", used, 1);

    // Both heads to D0 while D0 almost full for four cycles mid-turn
    doReset();
    bus.weight_VC0 = 3'd2;
    bus.weight_VC1 = 3'd2;
    vc0Q = '{6'h01, 6'h02, 6'h03};
    vc1Q = '{6'h08, 6'h09};
    expQ = '{6'h01, 6'h02, 6'h08, 6'h09, 6'h03};
    refreshInputs();
    applyStimulus();
    bus.almost_full_fifo_D0 = 1'b1;
    #1;
    checkOutput("full pops", {bus.pop_VC0_fifo, bus.pop_VC1_fifo}, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("full stall", bus.stall, 1);
    end
    checkOutput("full serving", bus.serving_VC1, 0);
    bus.almost_full_fifo_D0 = 1'b0;
    drain(10, used);
    checkOutput("full resume cycles", used, 4);

    // Zero weights give strict alternation
    doReset();
    bus.weight_VC0 = 3'd0;
    bus.weight_VC1 = 3'd0;
    vc0Q = '{6'h01, 6'h02, 6'h03};
    vc1Q = '{6'h08, 6'h09, 6'h0A};
    expQ = '{6'h01, 6'h08, 6'h02, 6'h09, 6'h03, 6'h0A};
    refreshInputs();
    drain(20, used);
    checkOutput("alternate cycles", used, 6);

    // Reset mid-burst in SERVE1 with cnt=1
    doReset();
    bus.weight_VC0 = 3'd1;
    bus.weight_VC1 = 3'd3;
    vc0Q = '{6'h01, 6'h02};
    vc1Q = '{6'h08, 6'h09, 6'h0A};
    expQ = '{6'h01};
    refreshInputs();
    applyStimulus();
    applyStimulus();
    checkOutput("pre-reset serving", bus.serving_VC1, 1);
    reset = 1'b1;
    #1;
    checkOutput("midreset pops", {bus.pop_VC0_fifo, bus.pop_VC1_fifo}, 0);
    checkOutput("midreset push", {bus.push_D0, bus.push_D1}, 0);
    checkOutput("midreset data", {bus.data_D0, bus.data_D1}, 0);
    checkOutput("midreset serving", bus.serving_VC1, 0);
    checkOutput("midreset stall", bus.stall, 0);
    vc0Q.delete();
    vc1Q.delete();
    refreshInputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.weight_VC1 = 3'd1;
    vc0Q = '{6'h05};
    vc1Q = '{6'h0C};
    expQ = '{6'h05, 6'h0C};
    refreshInputs();
    #1;
    checkOutput("post-reset first pop", {bus.pop_VC0_fifo, bus.pop_VC1_fifo}, 2'b10);
    drain(6, used);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
